// File: rtl/audio_codec_pkg.sv
// Shared constants for the WM8731 init sequencer: register map,
// power-up command table and sequencer state encoding.
package audio_codec_pkg;

  localparam logic [6:0] R0_LLIN   = 7'h00;
  localparam logic [6:0] R1_RLIN   = 7'h01;
  localparam logic [6:0] R2_LHPOUT = 7'h02;
  localparam logic [6:0] R3_RHPOUT = 7'h03;
  localparam logic [6:0] R4_APANA  = 7'h04;
  localparam logic [6:0] R5_DPATH  = 7'h05;
  localparam logic [6:0] R6_PDOWN  = 7'h06;
  localparam logic [6:0] R7_DAIF   = 7'h07;
  localparam logic [6:0] R8_SRATE  = 7'h08;
  localparam logic [6:0] R9_ACTIVE = 7'h09;
  localparam logic [6:0] R15_RESET = 7'h0F;

  localparam int NUM_CMDS = 11;

  function automatic logic [15:0] cmd(
    input logic [6:0] r,
    input logic [8:0] d
  );
    return {r, d};
  endfunction

  localparam logic [15:0] INIT_TABLE [NUM_CMDS] = '{
    cmd(R15_RESET, 9'h000),
    cmd(R6_PDOWN,  9'h000),
    cmd(R0_LLIN,   9'h017),
    cmd(R1_RLIN,   9'h017),
    cmd(R2_LHPOUT, 9'h079),
    cmd(R3_RHPOUT, 9'h079),
    cmd(R4_APANA,  9'h012),
    cmd(R5_DPATH,  9'h000),
    cmd(R7_DAIF,   9'h00E),
    cmd(R8_SRATE,  9'h000),
    cmd(R9_ACTIVE, 9'h001)
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_ACCEPT,
    S_XFER,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/audio_init_gap_timer.sv
// Down-counter that spaces consecutive I2C commands.
// load arms it with CYCLES; expired is high once it reaches zero.
module audio_init_gap_timer #(
  parameter int unsigned CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;

  logic [W-1:0] cnt;

  // reload on request, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= W'(CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/audio_codec_init_seq.sv
// WM8731 power-up sequencer and CPU/I2C arbiter.
// Optional: define AUDIO_INIT_RETRY_EN to re-issue no-acked table writes.
module audio_codec_init_seq
  import audio_codec_pkg::*;
#(
  parameter int unsigned SYSCLK     = 50,
  parameter int unsigned GAP_US     = 10,
  parameter logic [6:0]  CODEC_ID   = 7'h1A,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cpu_req,
  input  logic [6:0]  cpu_id,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_pending,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  err_index,
  output logic        i2c_req,
  output logic        i2c_wen,
  output logic [6:0]  i2c_slave_addr,
  output logic [15:0] i2c_writedata,
  input  logic        i2c_ready,
  input  logic        i2c_noack_err
);

`ifdef AUDIO_INIT_RETRY_EN
  localparam logic [1:0] MAX_RETRY = 2'd3;
`else
  localparam logic [1:0] MAX_RETRY = 2'd0;
`endif

  localparam logic [3:0] LAST_IDX = 4'(NUM_CMDS - 1);

  state_t      state, state_d;
  logic        boot, boot_d;
  logic [3:0]  idx, idx_d;
  logic [1:0]  retry, retry_d;
  logic        nack, nack_d;
  logic        cpu_mode, mode_d;
  logic        slot_full, slot_full_d;
  logic [6:0]  slot_id, slot_id_d;
  logic [15:0] slot_data, slot_data_d;
  logic [6:0]  addr_d;
  logic [15:0] data_d;
  logic        done_d, error_d;
  logic [3:0]  eidx_d;
  logic        gap_load, gap_expired;

  audio_init_gap_timer #(
    .CYCLES (SYSCLK * GAP_US)
  ) u_gap (
    .clk     (clk),
    .rst     (rst),
    .load    (gap_load),
    .expired (gap_expired)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      boot           <= AUTO_START;
      idx            <= '0;
      retry          <= '0;
      nack           <= 1'b0;
      cpu_mode       <= 1'b0;
      slot_full      <= 1'b0;
      slot_id        <= '0;
      slot_data      <= '0;
      i2c_slave_addr <= '0;
      i2c_writedata  <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_index      <= '0;
    end else begin
      state          <= state_d;
      boot           <= boot_d;
      idx            <= idx_d;
      retry          <= retry_d;
      nack           <= nack_d;
      cpu_mode       <= mode_d;
      slot_full      <= slot_full_d;
      slot_id        <= slot_id_d;
      slot_data      <= slot_data_d;
      i2c_slave_addr <= addr_d;
      i2c_writedata  <= data_d;
      done           <= done_d;
      error          <= error_d;
      err_index      <= eidx_d;
    end
  end

  // next-state, slot capture and command sequencing
  always_comb begin
    state_d     = state;
    boot_d      = boot;
    idx_d       = idx;
    retry_d     = retry;
    nack_d      = nack;
    mode_d      = cpu_mode;
    slot_full_d = slot_full;
    slot_id_d   = slot_id;
    slot_data_d = slot_data;
    addr_d      = i2c_slave_addr;
    data_d      = i2c_writedata;
    done_d      = done;
    error_d     = error;
    eidx_d      = err_index;
    gap_load    = 1'b0;
    i2c_req     = 1'b0;

    if (cpu_req && !slot_full) begin
      slot_full_d = 1'b1;
      slot_id_d   = cpu_id;
      slot_data_d = cpu_wdata;
    end

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start || boot) begin
          boot_d  = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          mode_d  = 1'b0;
          done_d  = 1'b0;
          error_d = 1'b0;
          eidx_d  = '0;
          state_d = S_LOAD;
        end else if (slot_full) begin
          mode_d  = 1'b1;
          addr_d  = slot_id;
          data_d  = slot_data;
          nack_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_LOAD: begin
        addr_d  = CODEC_ID;
        data_d  = INIT_TABLE[idx];
        nack_d  = 1'b0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (i2c_ready) begin
          i2c_req = 1'b1;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        nack_d = nack | i2c_noack_err;
        if (!i2c_ready)
          state_d = S_XFER;
      end
      S_XFER: begin
        nack_d = nack | i2c_noack_err;
        if (i2c_ready) begin
          gap_load = 1'b1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_expired) begin
          if (cpu_mode) begin
            slot_full_d = 1'b0;
            mode_d      = 1'b0;
            state_d     = done ? S_DONE : S_IDLE;
          end else if (nack && retry != MAX_RETRY) begin
            retry_d = retry + 1'b1;
            state_d = S_LOAD;
          end else begin
            if (nack && !error) begin
              error_d = 1'b1;
              eidx_d  = idx;
            end
            retry_d = '0;
            idx_d   = idx + 1'b1;
            if (idx == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign i2c_wen     = i2c_req;
  assign cpu_pending = slot_full;
  assign busy        = !cpu_mode &&
                       (state inside {S_LOAD, S_ISSUE,
                                      S_ACCEPT, S_XFER,
                                      S_GAP});

endmodule

// File: tb/tb_audio_codec_init_seq.sv
// Directed/random bench for audio_codec_init_seq with an I2C
// master responder model and a table-level reference of expected writes.
module tb_audio_codec_init_seq;

`ifdef AUDIO_INIT_RETRY_EN
  localparam int RETRIES = 3;
`else
  localparam int RETRIES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, cpu_req;
  logic [6:0]  cpu_id;
  logic [15:0] cpu_wdata;
  logic        cpu_pending, busy, done, error;
  logic [3:0]  err_index;
  logic        i2c_req, i2c_wen;
  logic [6:0]  i2c_slave_addr;
  logic [15:0] i2c_writedata;
  logic        i2c_ready, i2c_noack_err;

  audio_codec_init_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cpu_req        (cpu_req),
    .cpu_id         (cpu_id),
    .cpu_wdata      (cpu_wdata),
    .cpu_pending    (cpu_pending),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_index      (err_index),
    .i2c_req        (i2c_req),
    .i2c_wen        (i2c_wen),
    .i2c_slave_addr (i2c_slave_addr),
    .i2c_writedata  (i2c_writedata),
    .i2c_ready      (i2c_ready),
    .i2c_noack_err  (i2c_noack_err)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [11] = '{
    16'h1E00, 16'h0C00, 16'h0017, 16'h0217,
    16'h0479, 16'h0679, 16'h0812, 16'h0A00,
    16'h0E0E, 16'h1000, 16'h1201
  };

  int          cyc = 0;
  logic [22:0] log_cmd [0:255];
  int          log_cyc [0:255];
  int          nreq = 0;
  int          nacks_given = 0;
  int          fail_limit = 0;
  logic [15:0] fail_data = 16'h0479;
  int          bcnt = 0;
  logic        cur_nack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  logic [22:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // i2c_master stand-in: random transfer length, optional no-ack
  always @(posedge clk) begin
    i2c_noack_err <= 1'b0;
    if (rst) begin
      i2c_ready <= 1'b1;
      bcnt      <= 0;
    end else begin
      if (i2c_req && nreq < 256) begin
        log_cmd[nreq] <= {i2c_slave_addr, i2c_writedata};
        log_cyc[nreq] <= cyc;
        nreq          <= nreq + 1;
      end
      if (bcnt != 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 2 && cur_nack) i2c_noack_err <= 1'b1;
        if (bcnt == 1) i2c_ready <= 1'b1;
      end else if (i2c_req && i2c_ready) begin
        i2c_ready <= 1'b0;
        bcnt      <= $urandom_range(30, 4);
        if (i2c_writedata == fail_data &&
            nacks_given < fail_limit) begin
          cur_nack    <= 1'b1;
          nacks_given <= nacks_given + 1;
        end else begin
          cur_nack <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(input string tag);
    int k = 0;
    while (!(done && !busy && !cpu_pending && i2c_ready)
           && k < 20000) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 64'(k < 20000), 64'd1);
  endtask

  // expected writes for one table run; entry fidx no-acks nfail times
  task automatic expect_table(input int fidx, input int nfail,
                              output bit e_err, output int e_idx);
    int left = nfail;
    e_err = 1'b0;
    e_idx = 0;
    for (int i = 0; i < 11; i++) begin
      int tries = 0;
      bit again = 1'b1;
      while (again) begin
        bit bad;
        exp_q.push_back({7'h1A, tbl[i]});
        tries++;
        bad = (i == fidx) && (left > 0);
        if (bad) left--;
        again = bad && (tries <= RETRIES);
        if (bad && !again && !e_err) begin
          e_err = 1'b1;
          e_idx = i;
        end
      end
    end
  endtask

  task automatic compare_log(input string tag, input int base);
    check({tag, "_count"}, 64'(nreq - base), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && base + j < nreq; j++) begin
      check({tag, "_cmd"}, 64'(log_cmd[base + j]), 64'(exp_q[j]));
      if (j > 0)
        check({tag, "_spacing"},
              64'(log_cyc[base + j] - log_cyc[base + j - 1] >= 500),
              64'd1);
    end
    exp_q.delete();
  endtask

  initial begin
    bit          e_err;
    int          e_idx;
    int          base;
    int          k;
    logic [6:0]  rid;
    logic [15:0] rdata;

    rst = 1'b1; start = 1'b0; cpu_req = 1'b0;
    cpu_id = '0; cpu_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs",
          64'({busy, done, error, err_index, i2c_req, i2c_wen,
               i2c_slave_addr, i2c_writedata, cpu_pending}), 64'd0);
    tick();
    rst  = 1'b0;
    base = nreq;
    @(negedge clk);
    check("idle_after_reset", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    check("autostart_busy", 64'(busy), 64'd1);

    // run A: all ack, CPU request during init, start while busy
    repeat (46) tick();
    cpu_req = 1'b1; cpu_id = 7'h1A; cpu_wdata = 16'h0A08;
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpu_pending_set", 64'(cpu_pending), 64'd1);
    tick();
    cpu_req = 1'b1; cpu_id = 7'h33; cpu_wdata = 16'($urandom);
    tick();
    cpu_req = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_quiet("runA");
    expect_table(-1, 0, e_err, e_idx);
    exp_q.push_back({7'h1A, 16'h0A08});
    compare_log("runA", base);
    check("runA_done", 64'(done), 64'd1);
    check("runA_error", 64'(error), 64'd0);

    // idle CPU writes: two-cycle latency to i2c_req
    for (int n = 0; n < 3; n++) begin
      rid   = 7'($urandom);
      rdata = 16'($urandom);
      base  = nreq;
      cpu_req = 1'b1; cpu_id = rid; cpu_wdata = rdata;
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      check("lat_early_req", 64'({i2c_req, cpu_pending}), 64'b01);
      tick();
      @(negedge clk);
      check("lat_req", 64'({i2c_req, i2c_wen}), 64'b11);
      check("lat_cmd", 64'({i2c_slave_addr, i2c_writedata}),
            64'({rid, rdata}));
      wait_quiet("cpu_idle");
      exp_q.push_back({rid, rdata});
      compare_log("cpu_idle", base);
    end

    // run B: restart with simultaneous CPU request, entry 4 always no-acks
    fail_limit = nacks_given + 100;
    base = nreq;
    start = 1'b1; cpu_req = 1'b1;
    cpu_id = 7'h1A; cpu_wdata = 16'h0A08;
    tick();
    start = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("runB_clear", 64'({done, error, busy, cpu_pending}),
          64'b0011);
    wait_quiet("runB");
    expect_table(4, 100, e_err, e_idx);
    exp_q.push_back({7'h1A, 16'h0A08});
    compare_log("runB", base);
    check("runB_error", 64'(error), 64'(e_err));
    if (e_err) check("runB_err_index", 64'(err_index), 64'(e_idx));

    // run C: entry 4 no-acks exactly once
    fail_limit = nacks_given + 1;
    base = nreq;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_quiet("runC");
    expect_table(4, 1, e_err, e_idx);
    compare_log("runC", base);
    check("runC_error", 64'(error), 64'(e_err));
    if (e_err) check("runC_err_index", 64'(err_index), 64'(e_idx));

    // run D: reset during transfer of entry 6, then auto restart
    fail_limit = nacks_given;
    base = nreq;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (nreq < base + 7 && k < 20000) begin
      tick();
      k++;
    end
    check("runD_reach6", 64'(nreq >= base + 7), 64'd1);
    tick();
    @(negedge clk);
    check("runD_mid_xfer", 64'({busy, i2c_ready}), 64'b10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = nreq;
    @(negedge clk);
    check("runD_reset_outputs",
          64'({busy, done, error, err_index, i2c_req, i2c_wen,
               i2c_slave_addr, i2c_writedata, cpu_pending}), 64'd0);
    wait_quiet("runD");
    expect_table(-1, 0, e_err, e_idx);
    compare_log("runD", base);
    check("runD_flags", 64'({done, error}), 64'b10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
